// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared state encoding, segment bit positions and nibble helper for the scan driver
package seg7_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } scan_state_t;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Callers zero-pad their nibble vector to 32 bits, which covers every index a 3-bit cursor can reach.
    function automatic logic [3:0] nibble_sel(input logic [31:0] vec, input logic [2:0] idx);
        return vec[{idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/bin_to_7seg_decoder.sv
// rtl/bin_to_7seg_decoder.sv - combinational hex nibble to active-high a..g segment pattern
module bin_to_7seg_decoder (
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = 7'h00;
        case (i_nibble)
            4'h0: o_seg = 7'h3F;
            4'h1: o_seg = 7'h06;
            4'h2: o_seg = 7'h5B;
            4'h3: o_seg = 7'h4F;
            4'h4: o_seg = 7'h66;
            4'h5: o_seg = 7'h6D;
            4'h6: o_seg = 7'h7D;
            4'h7: o_seg = 7'h07;
            4'h8: o_seg = 7'h7F;
            4'h9: o_seg = 7'h6F;
            4'hA: o_seg = 7'h77;
            4'hB: o_seg = 7'h7C;
            4'hC: o_seg = 7'h39;
            4'hD: o_seg = 7'h5E;
            4'hE: o_seg = 7'h79;
            4'hF: o_seg = 7'h71;
            default: o_seg = 7'h00;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed 7-segment scanner with dwell, blank gap and frame-aligned data swap
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int DWELL_W    = 16,
    parameter int BLANK_W    = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ena,
    input  logic                    run,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data_in,
    input  logic [NUM_DIGITS-1:0]   digit_mask,
    input  logic [DWELL_W-1:0]      dwell,
    input  logic [BLANK_W-1:0]      blank,
    output logic [7:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic [2:0]              cur_digit,
    output logic                    frame_done
);

    localparam int CNT_W = (DWELL_W > BLANK_W) ? DWELL_W : BLANK_W;

    scan_state_t              r_state;
    logic [2:0]               r_idx;
    logic [CNT_W-1:0]         r_cnt;
    logic [4*NUM_DIGITS-1:0]  r_shadow;
    logic [4*NUM_DIGITS-1:0]  r_pending;
    logic                     r_pend_valid;
    logic [7:0]               r_seg;
    logic [NUM_DIGITS-1:0]    r_dig;
    logic [2:0]               r_cur;
    logic                     r_fd;

    logic [2:0]               w_lowest;
    logic [2:0]               w_next_hi;
    logic                     w_has_hi;
    logic                     w_any_en;
    logic                     w_start;
    logic                     w_adv_now;
    logic                     w_go_show;
    logic                     w_go_gap;
    logic                     w_go_idle;
    logic                     w_boundary;
    logic [2:0]               w_next_idx;
    logic [CNT_W-1:0]         w_dwell_init;
    logic [4*NUM_DIGITS-1:0]  w_shadow_nxt;
    logic [6:0]               w_seg7;
    logic [7:0]               w_seg8;

    always_comb begin
        w_lowest  = 3'd0;
        w_next_hi = 3'd0;
        w_has_hi  = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (digit_mask[i]) begin
                w_lowest = 3'(i);
                if (3'(i) > r_idx) begin
                    w_next_hi = 3'(i);
                    w_has_hi  = 1'b1;
                end
            end
        end
    end

    assign w_any_en     = |digit_mask;
    assign w_start      = run && (r_state == ST_IDLE) && w_any_en;
    assign w_adv_now    = (r_cnt == '0) &&
                          (((r_state == ST_SHOW) && (blank == '0)) || (r_state == ST_GAP));
    assign w_go_idle    = !run || (w_adv_now && !w_any_en);
    assign w_go_show    = run && (w_start || (w_adv_now && w_any_en));
    assign w_go_gap     = run && (r_state == ST_SHOW) && (r_cnt == '0) && (blank != '0);
    assign w_boundary   = w_go_show && !w_start && !w_has_hi;
    assign w_next_idx   = (w_start || !w_has_hi) ? w_lowest : w_next_hi;
    assign w_dwell_init = (dwell == '0) ? '0 : CNT_W'(dwell) - CNT_W'(1);

    // The digit lit on a wrap must already reflect the swapped frame, so decode from next-state shadow.
    always_comb begin
        w_shadow_nxt = r_shadow;
        if ((r_state == ST_IDLE) && load) begin
            w_shadow_nxt = data_in;
        end else if (w_boundary) begin
            if (load) begin
                w_shadow_nxt = data_in;
            end else if (r_pend_valid) begin
                w_shadow_nxt = r_pending;
            end
        end
    end

    bin_to_7seg_decoder u_dec (
        .i_nibble (nibble_sel(32'(w_shadow_nxt), w_next_idx)),
        .o_seg    (w_seg7)
    );

    always_comb begin
        w_seg8                = 8'h00;
        w_seg8[SEG_G:SEG_A]   = w_seg7;
        w_seg8[SEG_DP]        = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (ena) begin
            if (rst) begin
                r_state      <= ST_IDLE;
                r_idx        <= 3'd0;
                r_cnt        <= '0;
                r_shadow     <= '0;
                r_pending    <= '0;
                r_pend_valid <= 1'b0;
                r_seg        <= 8'h00;
                r_dig        <= '0;
                r_cur        <= 3'd0;
                r_fd         <= 1'b0;
            end else begin
                r_shadow <= w_shadow_nxt;
                if (w_boundary) begin
                    r_pend_valid <= 1'b0;
                end else if (load && (r_state != ST_IDLE)) begin
                    r_pending    <= data_in;
                    r_pend_valid <= 1'b1;
                end

                r_fd <= 1'b0;
                if (w_go_idle) begin
                    r_state <= ST_IDLE;
                    r_idx   <= 3'd0;
                    r_cnt   <= '0;
                    r_seg   <= 8'h00;
                    r_dig   <= '0;
                    r_cur   <= 3'd0;
                end else if (w_go_show) begin
                    r_state <= ST_SHOW;
                    r_idx   <= w_next_idx;
                    r_cnt   <= w_dwell_init;
                    r_seg   <= w_seg8;
                    r_dig   <= NUM_DIGITS'(1) << w_next_idx;
                    r_cur   <= w_next_idx;
                    r_fd    <= w_boundary;
                end else if (w_go_gap) begin
                    r_state <= ST_GAP;
                    r_cnt   <= CNT_W'(blank) - CNT_W'(1);
                    r_seg   <= 8'h00;
                    r_dig   <= '0;
                    r_cur   <= 3'd0;
                end else if (r_cnt != '0) begin
                    r_cnt <= r_cnt - CNT_W'(1);
                end
            end
        end
    end

    assign seg_out    = r_seg;
    assign dig_sel    = r_dig;
    assign cur_digit  = r_cur;
    assign frame_done = r_fd;

endmodule
